uart_txd_cfg: RTL



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_txd_cfg.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: parity encodings,
// FSM state type and the baud divisor calculation (also usable by a receiver).
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    // Rounded clock cycles per bit.
    function automatic int calc_baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..DIV-1 and flags the last cycle of each bit.
// Held at zero while clear_i is high so a new frame starts on a clean boundary.
module uart_baud_tick #(
    parameter int DIV = 434
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_txd_cfg.sv
// Configurable UART transmitter (data width, parity, stop bits, baud rate).
// Optional line-break support is enabled with the macro UART_TXD_CFG_BREAK_EN.
module uart_txd_cfg
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk50M,
    input  logic              rst_n,
    input  logic              txd_cmd,
    input  logic [DATA_W-1:0] txd_data,
`ifdef UART_TXD_CFG_BREAK_EN
    input  logic              txd_break,
`endif
    output logic              txd_flag,
    output logic              txd_busy,
    output logic              txd_pin
);

    localparam int BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
    localparam int BW       = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        DATA_W < 5 || DATA_W > 9 || BAUD_DIV < 2) begin : g_illegal_cfg
        $error("uart_txd_cfg: illegal parameter combination");
    end

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              par_q, par_d;
    logic              pin_q, pin_d;
    logic              busy_q, busy_d;
    logic              flag_q, flag_d;
    logic              bit_end;
    logic              brk_req;

`ifdef UART_TXD_CFG_BREAK_EN
    assign brk_req = txd_break;
`else
    assign brk_req = 1'b0;
`endif

    uart_baud_tick #(
        .DIV(BAUD_DIV)
    ) u_baud_tick (
        .clk_i    (clk50M),
        .rst_n_i  (rst_n),
        .clear_i  (state_q == S_IDLE),
        .bit_end_o(bit_end)
    );

    // The bit counter is shared: data bit index in DATA, stop bit index in STOP.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        flag_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (txd_cmd && !brk_req) begin
                    state_d = S_START;
                    shift_d = txd_data;
                    par_d   = (PARITY == PAR_ODD) ? ~^txd_data : ^txd_data;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                        flag_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level is decoded from the next state so txd_pin can be a plain flop.
    always_comb begin
        pin_d = 1'b1;
        unique case (state_d)
            S_START:  pin_d = 1'b0;
            S_DATA:   pin_d = shift_d[0];
            S_PARITY: pin_d = par_d;
            default:  pin_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        if ((state_q == S_IDLE) && brk_req) begin
            pin_d  = 1'b0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            pin_q   <= 1'b1;
            busy_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            pin_q   <= pin_d;
            busy_q  <= busy_d;
            flag_q  <= flag_d;
        end
    end

    assign txd_pin  = pin_q;
    assign txd_busy = busy_q;
    assign txd_flag = flag_q;

endmodule
